// File: rtl/dlbf_coeffs_axis_master.sv
// dlbf_coeffs_axis_master
// Streams beamformer coefficients from coefficient BRAM port B out on an
// AXI4-Stream master. Reads are prefetched into a small FIFO. A read is only
// issued while FIFO occupancy plus reads still in the BRAM pipe leave a free
// slot, so returning read data always has room and the stream may stall freely.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a rising edge on go; configuration latched on it
// RUN    | issuing BRAM reads and streaming beats until the final tlast
// DONE   | run complete, done held high until go returns low
module dlbf_coeffs_axis_master #(
    parameter int DATA_W     = 64,
    parameter int RAM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              m_axis_clk_i,
    input  logic              m_axis_rst_i,
    input  logic              go_i,
    input  logic [11:0]       block_size_i,
    input  logic [11:0]       niter_i,
    input  logic [15:0]       rollover_addr_i,
    output logic              bram_enb_o,
    output logic [15:0]       bram_addrb_o,
    input  logic [DATA_W-1:0] bram_doutb_i,
    output logic [DATA_W-1:0] m_axis_tdata_o,
    output logic              m_axis_tvalid_o,
    input  logic              m_axis_tready_i,
    output logic              m_axis_tlast_o,
    output logic              done_o,
    output logic [15:0]       addrb_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic              go_q;
    logic [11:0]       blk_size_q;
    logic [11:0]       niter_q;
    logic [15:0]       roll_q;
    logic [23:0]       total_q;
    logic [23:0]       issued_q;
    logic [15:0]       addr_q;
    logic [15:0]       addr_d;
    logic [11:0]       beat_cnt_q;
    logic [11:0]       blk_cnt_q;
    logic              done_q;

    logic [RAM_LAT-1:0] vpipe_q;
    logic [CW-1:0]      inflight;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic fifo_nonempty;
    logic push;
    logic pop;
    logic last_beat;
    logic issue;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Count reads sitting in the BRAM latency pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LAT; i++) begin
            inflight = inflight + CW'(vpipe_q[i]);
        end
    end

    // Read issue, handshake and beat bookkeeping derived from registered state.
    always_comb begin
        fifo_nonempty = (count_q != '0);
        issue         = (state_q == S_RUN) && (issued_q < total_q) &&
                        ((count_q + inflight) < CW'(FIFO_DEPTH));
        push          = vpipe_q[RAM_LAT-1];
        pop           = fifo_nonempty && m_axis_tready_i;
        last_beat     = (beat_cnt_q == blk_size_q - 12'd1);
        addr_d        = (addr_q == roll_q - 16'd1) ? 16'd0 : addr_q + 16'd1;
    end

    // Run-control FSM: configuration latch, read address, beat/block counters, done.
    always_ff @(posedge m_axis_clk_i) begin
        if (m_axis_rst_i) begin
            state_q    <= S_IDLE;
            go_q       <= 1'b0;
            blk_size_q <= '0;
            niter_q    <= '0;
            roll_q     <= '0;
            total_q    <= '0;
            issued_q   <= '0;
            addr_q     <= '0;
            beat_cnt_q <= '0;
            blk_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            go_q <= go_i;
            case (state_q)
                S_IDLE: begin
                    if (go_i && !go_q) begin
                        blk_size_q <= block_size_i;
                        niter_q    <= niter_i;
                        roll_q     <= rollover_addr_i;
                        total_q    <= 24'(block_size_i) * 24'(niter_i);
                        issued_q   <= '0;
                        addr_q     <= '0;
                        beat_cnt_q <= '0;
                        blk_cnt_q  <= '0;
                        if (block_size_i == 12'd0 || niter_i == 12'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        issued_q <= issued_q + 24'd1;
                        addr_q   <= addr_d;
                    end
                    if (pop) begin
                        if (last_beat) begin
                            beat_cnt_q <= '0;
                            if (blk_cnt_q == niter_q - 12'd1) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                blk_cnt_q <= blk_cnt_q + 12'd1;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 12'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (!go_i) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Valid pipe tracking BRAM read latency; flushing it on reset drops late data.
    always_ff @(posedge m_axis_clk_i) begin
        if (m_axis_rst_i) begin
            vpipe_q <= '0;
        end else begin
            vpipe_q[0] <= issue;
            for (int i = 1; i < RAM_LAT; i++) begin
                vpipe_q[i] <= vpipe_q[i-1];
            end
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide at any level.
    always_ff @(posedge m_axis_clk_i) begin
        if (m_axis_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage, written with BRAM read data as it emerges from the pipe.
    always_ff @(posedge m_axis_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bram_doutb_i;
        end
    end

    assign bram_enb_o      = issue;
    assign bram_addrb_o    = addr_q;
    assign addrb_o         = addr_q;
    assign m_axis_tvalid_o = fifo_nonempty;
    assign m_axis_tdata_o  = fifo_nonempty ? mem_q[rd_ptr_q] : '0;
    assign m_axis_tlast_o  = fifo_nonempty && last_beat;
    assign done_o          = done_q;

endmodule

// File: tb/tb_dlbf_coeffs_axis_master.sv
// Testbench for dlbf_coeffs_axis_master: BRAM model with fixed read latency,
// randomized tready, beat stream checked against row/tlast rules.
module tb_dlbf_coeffs_axis_master;

    localparam int DATA_W = 64;
    localparam int LAT    = 2;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              go;
    logic [11:0]       block_size;
    logic [11:0]       niter;
    logic [15:0]       rollover;
    logic              bram_enb;
    logic [15:0]       bram_addrb;
    logic [DATA_W-1:0] bram_doutb;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              done;
    logic [15:0]       addrb;

    logic [47:0]       salt_g;
    logic [DATA_W-1:0] rd_pipe [LAT];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dlbf_coeffs_axis_master #(
        .DATA_W(DATA_W), .RAM_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .m_axis_clk_i   (clk),
        .m_axis_rst_i   (rst),
        .go_i           (go),
        .block_size_i   (block_size),
        .niter_i        (niter),
        .rollover_addr_i(rollover),
        .bram_enb_o     (bram_enb),
        .bram_addrb_o   (bram_addrb),
        .bram_doutb_i   (bram_doutb),
        .m_axis_tdata_o (tdata),
        .m_axis_tvalid_o(tvalid),
        .m_axis_tready_i(tready),
        .m_axis_tlast_o (tlast),
        .done_o         (done),
        .addrb_o        (addrb)
    );

    // BRAM port B: row r holds {salt, r}; data appears LAT cycles after enb.
    always @(posedge clk) begin
        rd_pipe[0] <= bram_enb ? {salt_g, bram_addrb} : 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_doutb = rd_pipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_stream(input int bs, input int ni, input int roll, input int pct,
                              input int abort_after, input int chg_cyc);
        int total, k, cyc, first_v, last_hs, n_enb, addr_bad, pair_bad, budget, rolln;
        int stall_bad, extra_enb;
        bit stalled, fin;
        logic [63:0] st_data;
        logic st_last;
        rolln = (roll == 0) ? 65536 : roll;
        total = bs * ni;
        budget = total * 40 + 40;
        k = 0; cyc = 0; first_v = -1; last_hs = -1; n_enb = 0;
        addr_bad = 0; pair_bad = 0; stall_bad = 0; extra_enb = 0;
        stalled = 0; fin = 0; st_data = '0; st_last = 0;
        block_size = 12'(bs); niter = 12'(ni); rollover = 16'(roll);
        @(negedge clk);
        go = 1'b1;
        while (!fin && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cyc == chg_cyc) block_size = 12'(bs + 3);
            if (bram_enb) begin
                if (bram_addrb != 16'(n_enb % rolln)) addr_bad++;
                n_enb++;
            end
            if (bram_addrb != addrb) pair_bad++;
            if (stalled && (!tvalid || tdata !== st_data || tlast !== st_last)) stall_bad++;
            if (tvalid && first_v < 0) first_v = cyc;
            tready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
            if (tvalid && tready) begin
                chk("tdata", tdata, {salt_g, 16'(k % rolln)});
                chk("tlast", 64'(tlast), 64'((k % bs) == (bs - 1)));
                last_hs = cyc;
                k++;
                if (k == total) fin = 1;
            end
            stalled = tvalid && !tready;
            st_data = tdata;
            st_last = tlast;
            if (abort_after >= 0 && k == abort_after) break;
        end
        chk("addr_seq", 64'(addr_bad), 0);
        chk("addrb_eq", 64'(pair_bad), 0);
        chk("stall_stable", 64'(stall_bad), 0);
        if (abort_after >= 0) begin
            @(negedge clk);
            rst = 1'b1; go = 1'b0; tready = 1'b0;
            @(negedge clk);
            chk("rst_outs", {bram_enb, tvalid, tlast, done, 60'(bram_addrb)}, 0);
            chk("rst_tdata", tdata, 0);
            chk("rst_addrb", 64'(addrb), 0);
            rst = 1'b0;
            @(negedge clk);
            return;
        end
        if (!fin) begin
            chk("timeout", 1, 0);
            return;
        end
        if (pct >= 100) begin
            chk("first_valid", 64'(first_v), 64'(LAT + 2));
            chk("gapless", 64'(last_hs - first_v), 64'(total - 1));
        end
        @(negedge clk);
        chk("done_after_last", {63'(0), done}, 1);
        chk("tvalid_after_last", {63'(0), tvalid}, 0);
        chk("read_count", 64'(n_enb + (bram_enb ? 1 : 0)), 64'(total));
        // go still high: must stay in DONE with no restart
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bram_enb || tvalid || !done) extra_enb++;
        end
        chk("done_hold", 64'(extra_enb), 0);
        go = 1'b0;
        @(negedge clk);
        chk("done_clear", {63'(0), done}, 0);
    endtask

    task automatic zero_run(input int bs, input int ni);
        int seen_enb, seen_valid, done_cyc;
        seen_enb = 0; seen_valid = 0; done_cyc = -1;
        block_size = 12'(bs); niter = 12'(ni); rollover = 16'd16;
        @(negedge clk);
        go = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (bram_enb) seen_enb++;
            if (tvalid) seen_valid++;
            if (done && done_cyc < 0) done_cyc = c;
        end
        chk("zero_enb", 64'(seen_enb), 0);
        chk("zero_valid", 64'(seen_valid), 0);
        chk("zero_done_lat", 64'(done_cyc >= 1 && done_cyc <= 2), 1);
        go = 1'b0;
        @(negedge clk);
        chk("zero_done_clear", {63'(0), done}, 0);
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; tready = 1'b0;
        block_size = '0; niter = '0; rollover = '0; salt_g = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {bram_enb, tvalid, tlast, done, 60'(bram_addrb)}, 0);
        chk("reset_tdata", tdata, 0);
        rst = 1'b0;
        @(negedge clk);

        salt_g = 48'h0;
        run_stream(4, 2, 1024, 100, -1, 0);
        salt_g = {$urandom(), 16'($urandom())};
        run_stream(3, 3, 5, 100, -1, 0);
        salt_g = {$urandom(), 16'($urandom())};
        run_stream(16, 4, 1024, 50, -1, 0);
        zero_run(0, 3);
        zero_run(5, 0);
        salt_g = 48'hAAAA_5555_0001;
        run_stream(8, 4, 1024, 100, 6, 0);
        salt_g = 48'h1234_5678_9ABC;
        run_stream(8, 4, 1024, 100, -1, 0);
        salt_g = {$urandom(), 16'($urandom())};
        run_stream(5, 3, 7, 70, -1, 4);
        salt_g = {$urandom(), 16'($urandom())};
        run_stream(2, 3, 0, 100, -1, 0);
        for (int r = 0; r < 4; r++) begin
            salt_g = {$urandom(), 16'($urandom())};
            run_stream($urandom_range(8, 1), $urandom_range(4, 1), $urandom_range(12, 1),
                       $urandom_range(100, 25), -1, 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
